router_input_unit: RTL

//  Per-input-port front end of a mesh router, sitting directly upstream of one Switch input.

---
 rtl/router_input_unit.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/router_input_unit.sv
// Mesh router input port: flit FIFO, XY route computation, and switch path
// reserve / forward / relieve sequencing for one switch input.
module router_input_unit #(
   parameter int N             = 4,
   parameter int X_POS         = 0,
   parameter int Y_POS         = 0,
   parameter int OUTPUTS       = 5,
   parameter int DATA_WIDTH    = 8,
   parameter int REQUEST_WIDTH = 3,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_WIDTH-1:0]    data_in,
   input  logic                     valid_in,
   output logic                     ready_in,
   output logic                     routeReserveRequestValid,
   output logic [REQUEST_WIDTH-1:0] routeReserveRequest,
   input  logic                     routeReserveStatus,
   output logic                     routeRelieve,
   output logic [DATA_WIDTH-1:0]    data_out,
   output logic                     valid_out,
   input  logic                     ready_out,
   output logic                     protocolError
);
   localparam int XW = $clog2(N);
   localparam int DW = DATA_WIDTH;
   localparam int RW = REQUEST_WIDTH;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [XW-1:0] X_COORD    = XW'(X_POS);
   localparam logic [XW-1:0] Y_COORD    = XW'(Y_POS);
   localparam logic [AW:0]   DEPTH_CNT  = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]   ZERO_CNT   = {(AW+1){1'b0}};
   localparam logic [RW-1:0] PORT_LOCAL = RW'(0);
   localparam logic [RW-1:0] PORT_NORTH = RW'(1);
   localparam logic [RW-1:0] PORT_EAST  = RW'(2);
   localparam logic [RW-1:0] PORT_SOUTH = RW'(3);
   localparam logic [RW-1:0] PORT_WEST  = RW'(OUTPUTS - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQUEST = 2'd1,
      ACTIVE  = 2'd2,
      RELIEVE = 2'd3
   } state_t;

   logic [DW-1:0] mem_r [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr_r;
   logic [AW-1:0] wr_ptr_r;
   logic [AW:0]   count_r;
   state_t        state_r;
   logic [RW-1:0] port_r;
   logic          req_valid_r;
   logic          relieve_r;
   logic          valid_out_r;
   logic [DW-1:0] data_out_r;
   logic          error_r;

   logic [DW-1:0] head_s;
   logic [DW-1:0] head_nxt_s;
   logic [XW-1:0] dx_s;
   logic [XW-1:0] dy_s;
   logic [RW-1:0] route_s;
   logic          empty_s;
   logic          full_s;
   logic          push_s;
   logic          fwd_pop_s;
   logic          discard_s;
   logic          pop_s;
   logic          tail_pop_s;
   logic          valid_nxt_s;
   logic [AW:0]   remain_s;
   logic [AW:0]   count_nxt_s;
   logic [AW-1:0] rd_ptr_nxt_s;

   assign ready_in                 = !rst && !full_s;
   assign routeReserveRequestValid = req_valid_r;
   assign routeReserveRequest      = port_r;
   assign routeRelieve             = relieve_r;
   assign data_out                 = data_out_r;
   assign valid_out                = valid_out_r;
   assign protocolError            = error_r;

   // FIFO status, XY routing of the head flit, and next-cycle output lookahead
   always_comb begin
      head_s       = mem_r[rd_ptr_r];
      empty_s      = (count_r == ZERO_CNT);
      full_s       = (count_r == DEPTH_CNT);
      push_s       = valid_in && ready_in;
      fwd_pop_s    = (state_r == ACTIVE) && valid_out_r && ready_out;
      // Type bit DW-2 is set for HEAD and HEAD_TAIL, bit DW-1 for TAIL and HEAD_TAIL.
      discard_s    = (state_r == IDLE) && !empty_s && !head_s[DW-2];
      pop_s        = fwd_pop_s || discard_s;
      tail_pop_s   = fwd_pop_s && data_out_r[DW-1];
      remain_s     = count_r - (AW+1)'(pop_s);
      count_nxt_s  = remain_s + (AW+1)'(push_s);
      rd_ptr_nxt_s = rd_ptr_r + AW'(pop_s);
      // A flit pushed into an otherwise drained FIFO becomes the next head directly.
      head_nxt_s   = (remain_s == ZERO_CNT) ? data_in : mem_r[rd_ptr_nxt_s];
      valid_nxt_s  = (state_r == ACTIVE) && !tail_pop_s && (count_nxt_s != ZERO_CNT);
      dx_s         = head_s[XW-1:0];
      dy_s         = head_s[2*XW-1:XW];
      if (dx_s > X_COORD) begin
         route_s = PORT_EAST;
      end else if (dx_s < X_COORD) begin
         route_s = PORT_WEST;
      end else if (dy_s > Y_COORD) begin
         route_s = PORT_NORTH;
      end else if (dy_s < Y_COORD) begin
         route_s = PORT_SOUTH;
      end else begin
         route_s = PORT_LOCAL;
      end
   end

   // Flit storage write port
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= data_in;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_r <= {AW{1'b0}};
         wr_ptr_r <= {AW{1'b0}};
         count_r  <= ZERO_CNT;
      end else begin
         rd_ptr_r <= rd_ptr_nxt_s;
         wr_ptr_r <= wr_ptr_r + AW'(push_s);
         count_r  <= count_nxt_s;
      end
   end

   // Packet sequencing FSM with registered handshake and data outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         port_r      <= {RW{1'b0}};
         req_valid_r <= 1'b0;
         relieve_r   <= 1'b0;
         valid_out_r <= 1'b0;
         data_out_r  <= {DW{1'b0}};
         error_r     <= 1'b0;
      end else begin
         relieve_r   <= 1'b0;
         valid_out_r <= valid_nxt_s;
         data_out_r  <= valid_nxt_s ? head_nxt_s : {DW{1'b0}};
         case (state_r)
            IDLE: begin
               if (!empty_s) begin
                  if (head_s[DW-2]) begin
                     state_r     <= REQUEST;
                     port_r      <= route_s;
                     req_valid_r <= 1'b1;
                  end else begin
                     error_r <= 1'b1;
                  end
               end
            end
            REQUEST: begin
               if (routeReserveStatus) begin
                  state_r     <= ACTIVE;
                  req_valid_r <= 1'b0;
               end
            end
            ACTIVE: begin
               if (tail_pop_s) begin
                  state_r   <= RELIEVE;
                  relieve_r <= 1'b1;
               end
            end
            RELIEVE: begin
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end
endmodule
